// File: rtl/phase_unwrapper_sequencer.sv
// Run sequencer for the phase unwrapper: flushes the datapath, accumulates for a
// programmed length, drains the pipeline, then captures the final phase and reports done.
module phase_unwrapper_sequencer #(
    parameter int DOUT_WIDTH   = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int FLUSH_CYCLES = 4,
    parameter int PIPE_LAT     = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         abort,
    input  logic [CNT_WIDTH-1:0]         meas_len,
    input  logic signed [DOUT_WIDTH-1:0] phase_in,
    output logic                         unwrap_rst,
    output logic                         unwrap_acc_on,
    output logic                         busy,
    output logic                         done,
    output logic                         aborted,
    output logic signed [DOUT_WIDTH-1:0] phase_result,
    output logic                         overflow,
    output logic [CNT_WIDTH-1:0]         cycle_count
);

    typedef enum logic [1:0] {IDLE, FLUSH, ACQ, DRAIN} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(PIPE_LAT - 1);

    state_t               state_r;
    logic [CNT_WIDTH-1:0] len_r;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [1:0]           phase_top_r;
    logic                 wrap_s;

    // A full-scale wrap shows up as the sign/next bits jumping between 01 and 10.
    function automatic logic wrap_detect(input logic [1:0] prev_top, input logic [1:0] cur_top);
        return ((prev_top == 2'b01) && (cur_top == 2'b10)) ||
               ((prev_top == 2'b10) && (cur_top == 2'b01));
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : value + CNT_ONE;
    endfunction

    assign wrap_s = wrap_detect(phase_top_r, phase_in[DOUT_WIDTH-1 -: 2]);

    // Run sequencing FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= IDLE;
            len_r         <= CNT_ZERO;
            cnt_r         <= CNT_ZERO;
            phase_top_r   <= 2'b00;
            unwrap_rst    <= 1'b1;
            unwrap_acc_on <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            phase_result  <= {DOUT_WIDTH{1'b0}};
            overflow      <= 1'b0;
            cycle_count   <= CNT_ZERO;
        end else begin
            done        <= 1'b0;
            aborted     <= 1'b0;
            phase_top_r <= phase_in[DOUT_WIDTH-1 -: 2];
            if (((state_r == ACQ) || (state_r == DRAIN)) && wrap_s) begin
                overflow <= 1'b1;
            end
            if (abort && (state_r != IDLE)) begin
                // The cycle in which abort is seen still counts as an executed ACQ cycle.
                if (state_r == ACQ) begin
                    cycle_count <= sat_inc(cycle_count);
                end
                state_r       <= IDLE;
                unwrap_rst    <= 1'b0;
                unwrap_acc_on <= 1'b0;
                busy          <= 1'b0;
                aborted       <= 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        unwrap_rst    <= 1'b0;
                        unwrap_acc_on <= 1'b0;
                        if (start && !abort) begin
                            len_r       <= meas_len;
                            cnt_r       <= FLUSH_LAST;
                            overflow    <= 1'b0;
                            cycle_count <= CNT_ZERO;
                            busy        <= 1'b1;
                            unwrap_rst  <= 1'b1;
                            state_r     <= FLUSH;
                        end
                    end
                    FLUSH: begin
                        if (cnt_r == CNT_ZERO) begin
                            unwrap_rst <= 1'b0;
                            if (len_r == CNT_ZERO) begin
                                cnt_r   <= DRAIN_LAST;
                                state_r <= DRAIN;
                            end else begin
                                cnt_r         <= len_r;
                                unwrap_acc_on <= 1'b1;
                                state_r       <= ACQ;
                            end
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ACQ: begin
                        cycle_count <= sat_inc(cycle_count);
                        if (cnt_r == CNT_ONE) begin
                            unwrap_acc_on <= 1'b0;
                            cnt_r         <= DRAIN_LAST;
                            state_r       <= DRAIN;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    DRAIN: begin
                        if (cnt_r == CNT_ZERO) begin
                            phase_result <= phase_in;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            state_r      <= IDLE;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    default: begin
                        state_r       <= IDLE;
                        unwrap_rst    <= 1'b0;
                        unwrap_acc_on <= 1'b0;
                        busy          <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_unwrapper_sequencer.sv
// Bench for phase_unwrapper_sequencer: drives runs against a simple ramp unwrapper and
// checks timing, captured phase, overflow and abort/reset behaviour against arithmetic expectations.
module tb_phase_unwrapper_sequencer;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int FLUSH = 4;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic resetn, start, abort;
    logic [CW-1:0] meas_len;
    logic signed [DW-1:0] phase_in = '0;
    logic unwrap_rst, unwrap_acc_on, busy, done, aborted, overflow;
    logic signed [DW-1:0] phase_result;
    logic [CW-1:0] cycle_count;

    int total = 0;
    int bad = 0;
    int unsigned step = 5;
    logic [DW-1:0] model_acc = '0;

    always #5 clk = ~clk;

    phase_unwrapper_sequencer #(
        .DOUT_WIDTH(DW), .CNT_WIDTH(CW), .FLUSH_CYCLES(FLUSH), .PIPE_LAT(LAT)
    ) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .meas_len(meas_len),
        .phase_in(phase_in), .unwrap_rst(unwrap_rst), .unwrap_acc_on(unwrap_acc_on),
        .busy(busy), .done(done), .aborted(aborted), .phase_result(phase_result),
        .overflow(overflow), .cycle_count(cycle_count)
    );

    // Stand-in unwrapper: ramps by step per enabled cycle, output one register later.
    always @(posedge clk) begin
        if (unwrap_rst) model_acc <= '0;
        else if (unwrap_acc_on) model_acc <= model_acc + DW'(step);
        phase_in <= model_acc;
    end

    // Issue one start and watch the run until done or the cycle budget expires.
    task automatic do_run(input int len, input int restart_at, output int rst_cyc,
                          output int acc_cyc, output int done_idx, output int busy_bad,
                          output bit timed_out);
        bit seen;
        seen = 1'b0; rst_cyc = 0; acc_cyc = 0; done_idx = -1; busy_bad = 0;
        @(negedge clk); start = 1'b1; meas_len = CW'(len);
        @(negedge clk); start = 1'b0;
        for (int idx = 1; idx <= len + 64 && !seen; idx++) begin
            if (idx > 1) @(negedge clk);
            if (unwrap_rst) rst_cyc++;
            if (unwrap_acc_on) acc_cyc++;
            if (done) begin
                seen = 1'b1; done_idx = idx;
                if (busy) busy_bad++;
            end else if (!busy) busy_bad++;
            start = (idx == restart_at);
            if (idx == restart_at) meas_len = CW'(50);
        end
        start = 1'b0;
        timed_out = !seen;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; meas_len = '0;
        repeat (3) @(negedge clk);
        total++; if (unwrap_rst !== 1'b1) begin bad++; $display("FAIL reset_unwrap_rst got=%0b want=1", unwrap_rst); end
        total++; if ({unwrap_acc_on, busy, done, aborted, overflow} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {unwrap_acc_on, busy, done, aborted, overflow}); end
        total++; if (phase_result !== 16'sd0 || cycle_count !== 32'd0) begin bad++; $display("FAIL reset_values got=%0d/%0d want=0/0", phase_result, cycle_count); end
        resetn = 1'b1;
        @(negedge clk);
        total++; if (unwrap_rst !== 1'b0) begin bad++; $display("FAIL release_unwrap_rst got=%0b want=0", unwrap_rst); end
    endtask

    task automatic test_basic_run();
        int r, a, d, b; bit t;
        step = 5;
        do_run(10, 0, r, a, d, b, t);
        total++; if (t) begin bad++; $display("FAIL basic_timeout got=timeout want=done"); end
        total++; if (r !== FLUSH) begin bad++; $display("FAIL basic_rst_cycles got=%0d want=%0d", r, FLUSH); end
        total++; if (a !== 10) begin bad++; $display("FAIL basic_acc_cycles got=%0d want=10", a); end
        total++; if (d !== FLUSH + 10 + LAT + 1) begin bad++; $display("FAIL basic_done_time got=%0d want=%0d", d, FLUSH + 10 + LAT + 1); end
        total++; if (b !== 0) begin bad++; $display("FAIL basic_busy got=%0d bad samples want=0", b); end
        total++; if (cycle_count !== 32'd10) begin bad++; $display("FAIL basic_cycle_count got=%0d want=10", cycle_count); end
        total++; if (phase_result !== 16'sd50) begin bad++; $display("FAIL basic_phase got=%0d want=50", phase_result); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0b want=0", overflow); end
    endtask

    task automatic test_random_runs();
        int r, a, d, b, len; bit t;
        logic [DW-1:0] exp_phase;
        for (int i = 0; i < 8; i++) begin
            len = int'($urandom_range(1, 20));
            step = $urandom_range(1, 3000);
            exp_phase = DW'(len * int'(step));
            do_run(len, 0, r, a, d, b, t);
            total++; if (t || a !== len) begin bad++; $display("FAIL rand_acc_cycles got=%0d want=%0d", a, len); end
            total++; if (phase_result !== exp_phase) begin bad++; $display("FAIL rand_phase got=%0d want=%0d", phase_result, $signed(exp_phase)); end
            total++; if (overflow !== (len * int'(step) > 32767)) begin bad++; $display("FAIL rand_overflow got=%0b want=%0b", overflow, len * int'(step) > 32767); end
            total++; if (cycle_count !== CW'(len)) begin bad++; $display("FAIL rand_cycle_count got=%0d want=%0d", cycle_count, len); end
        end
    endtask

    task automatic test_overflow_clear();
        int r, a, d, b; bit t;
        step = 4000;
        do_run(10, 0, r, a, d, b, t);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", overflow); end
        total++; if (phase_result !== -16'sd25536) begin bad++; $display("FAIL ovf_phase got=%0d want=-25536", phase_result); end
        step = 5;
        do_run(3, 0, r, a, d, b, t);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", overflow); end
        total++; if (phase_result !== 16'sd15) begin bad++; $display("FAIL ovf_next_phase got=%0d want=15", phase_result); end
    endtask

    task automatic test_zero_len();
        int r, a, d, b; bit t;
        step = 5;
        do_run(0, 0, r, a, d, b, t);
        total++; if (t || r !== FLUSH || a !== 0) begin bad++; $display("FAIL zero_cycles got=rst%0d/acc%0d want=rst%0d/acc0", r, a, FLUSH); end
        total++; if (d !== FLUSH + LAT + 1) begin bad++; $display("FAIL zero_done_time got=%0d want=%0d", d, FLUSH + LAT + 1); end
        total++; if (cycle_count !== 32'd0 || phase_result !== 16'sd0) begin bad++; $display("FAIL zero_result got=%0d/%0d want=0/0", cycle_count, phase_result); end
    endtask

    task automatic test_abort();
        int r, a, d, b, n; bit t, done_seen;
        step = 1;
        do_run(5, 3, r, a, d, b, t);
        total++; if (t || a !== 5 || phase_result !== 16'sd5) begin bad++; $display("FAIL start_while_busy got=acc%0d/phase%0d want=acc5/phase5", a, phase_result); end
        step = 9;
        @(negedge clk); start = 1'b1; meas_len = 32'd10;
        @(negedge clk); start = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && n < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (unwrap_acc_on) n++;
        end
        total++; if (n !== 3) begin bad++; $display("FAIL abort_reach_acq got=%0d want=3", n); end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        total++; if ({aborted, busy, unwrap_acc_on, unwrap_rst, done} !== 5'b10000) begin bad++; $display("FAIL abort_flags got=%b want=10000", {aborted, busy, unwrap_acc_on, unwrap_rst, done}); end
        done_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        total++; if (done_seen || aborted !== 1'b0) begin bad++; $display("FAIL abort_no_done got=done%0b/aborted%0b want=0/0", done_seen, aborted); end
        total++; if (phase_result !== 16'sd5 || cycle_count !== 32'd3) begin bad++; $display("FAIL abort_hold got=%0d/%0d want=5/3", phase_result, cycle_count); end
        start = 1'b1; abort = 1'b1; meas_len = 32'd4;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        total++; if ({busy, aborted, unwrap_rst} !== 3'b000) begin bad++; $display("FAIL start_abort_idle got=%b want=000", {busy, aborted, unwrap_rst}); end
    endtask

    task automatic test_async_reset();
        int r, a, d, b; bit t;
        step = 5;
        @(negedge clk); start = 1'b1; meas_len = 32'd20;
        @(negedge clk); start = 1'b0;
        repeat (7) @(negedge clk);
        total++; if (unwrap_acc_on !== 1'b1) begin bad++; $display("FAIL areset_in_acq got=%0b want=1", unwrap_acc_on); end
        #2 resetn = 1'b0;
        #1;
        total++; if ({unwrap_rst, unwrap_acc_on, busy, done} !== 4'b1000) begin bad++; $display("FAIL areset_outputs got=%b want=1000", {unwrap_rst, unwrap_acc_on, busy, done}); end
        total++; if (cycle_count !== 32'd0 || phase_result !== 16'sd0) begin bad++; $display("FAIL areset_values got=%0d/%0d want=0/0", cycle_count, phase_result); end
        @(negedge clk); resetn = 1'b1;
        do_run(4, 0, r, a, d, b, t);
        total++; if (t || d !== FLUSH + 4 + LAT + 1 || b !== 0) begin bad++; $display("FAIL areset_rerun_timing got=%0d want=%0d", d, FLUSH + 4 + LAT + 1); end
        total++; if (phase_result !== 16'sd20 || cycle_count !== 32'd4) begin bad++; $display("FAIL areset_rerun_result got=%0d/%0d want=20/4", phase_result, cycle_count); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_random_runs();
        test_overflow_clear();
        test_zero_len();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_unwrapper_sequencer.md
Name: phase_unwrapper_sequencer

Overview:
- Sequences one measurement run of the phase unwrapper datapath.
- On a start request it flushes the unwrapper, runs the accumulator for a programmed number of cycles, freezes it, and waits out the datapath latency.
- It then captures the final unwrapped phase and reports done, with an overflow flag.
- Sits between the control registers (start/abort/length) and the unwrapper's rst/acc_on inputs.

Parameters:
- DOUT_WIDTH, 16, width of the unwrapped phase sampled from the unwrapper.
- CNT_WIDTH, 32, width of the measurement-length and cycle counters.
- FLUSH_CYCLES, 4, number of cycles unwrap_rst is held high at the start of a run (≥1).
- PIPE_LAT, 2, cycles from an acc_on change to the corresponding phase_out update (≥1).

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  run request, sampled every cycle.
- abort  in  1  cancel request, sampled every cycle.
- meas_len  in  CNT_WIDTH  accumulation length in cycles, latched on accepted start.
- phase_in  in  DOUT_WIDTH  signed phase_out from the unwrapper.
- unwrap_rst  out  1  reset to the unwrapper.
- unwrap_acc_on  out  1  accumulate enable to the unwrapper.
- busy  out  1  high from accepted start until done or abort.
- done  out  1  one-cycle pulse when phase_result is valid.
- aborted  out  1  one-cycle pulse on abort of an active run.
- phase_result  out  DOUT_WIDTH  signed captured final phase, held until the next done.
- overflow  out  1  sticky per run; wrap of phase_in detected during ACQ/DRAIN.
- cycle_count  out  CNT_WIDTH  ACQ cycles actually executed in the last run.

Behaviour:
- All outputs are registered.
- Reset values: unwrap_rst=1, unwrap_acc_on=0, busy=0, done=0, aborted=0, phase_result=0, overflow=0, cycle_count=0, state=IDLE.
- From the first clock edge after reset release: unwrap_rst=0.
- States: IDLE, FLUSH, ACQ, DRAIN.
- IDLE: unwrap_rst=0, unwrap_acc_on=0 (datapath frozen).
  - start=1 and abort=0 → latch meas_len, clear overflow and cycle_count, busy=1, go to FLUSH.
  - start while busy is ignored.
  - start and abort together in IDLE → stay in IDLE, no pulse.
- FLUSH: unwrap_rst=1, unwrap_acc_on=0 for exactly FLUSH_CYCLES cycles, then go to ACQ.
  - If latched meas_len=0, go straight to DRAIN instead.
- ACQ: unwrap_rst=0, unwrap_acc_on=1 for exactly meas_len cycles.
  - cycle_count increments once per ACQ cycle.
  - After the last cycle, go to DRAIN.
- DRAIN: unwrap_acc_on=0 for PIPE_LAT cycles.
  - On the final DRAIN cycle, phase_result<=phase_in.
  - On the next cycle, done=1, busy=0, go to IDLE.
- Overflow check, in ACQ and DRAIN:
  - Register the previous phase_in.
  - Set overflow if the top two bits go 01→10 or 10→01 between consecutive samples (wrap across full scale).
  - Sticky until the next accepted start.
- Abort:
  - abort=1 in FLUSH/ACQ/DRAIN → next cycle IDLE, unwrap_acc_on=0, unwrap_rst=0, busy=0, aborted=1 for one cycle, done=0.
  - phase_result is unchanged; cycle_count keeps the partial value.
  - abort in IDLE has no effect.
- Counter width:
  - The length counter counts down from the latched meas_len.
  - meas_len=2^CNT_WIDTH-1 must run the full count without wrap.
  - cycle_count saturates at all-ones.
- Asynchronous reset mid-run returns all outputs to reset values immediately.
- unwrap_rst is high during resetn=0.

Test Plan:
- Reset release with FLUSH_CYCLES=4, PIPE_LAT=2, then start with meas_len=10 → unwrap_rst high exactly 4 cycles, unwrap_acc_on high exactly 10 cycles, done 2+1 cycles after acc_on falls, cycle_count=10, busy spans the whole run.
- Model unwrapper (phase += 5 per acc_on cycle, PIPE_LAT=2) with meas_len=10 → phase_result=50, overflow=0.
- Model phase ramp crossing +32767→-32768 during ACQ → overflow=1 at done; next start clears it to 0.
- start with meas_len=0 → FLUSH 4 cycles, no acc_on cycle, done after DRAIN, cycle_count=0, phase_result=0.
- abort on the 3rd ACQ cycle → aborted pulse, done never asserts, phase_result keeps its prior value, cycle_count=3; start during run, and start+abort together in IDLE, both ignored.
- resetn asserted mid-ACQ → unwrap_rst=1, unwrap_acc_on=0, busy=0 asynchronously; clean run afterwards.
